// File: rtl/hd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hd_arbiter
// Purpose  : Shares one HD access port between the BIOS loader and the CPU.
//            The BIOS has exclusive access while active; after that the two
//            requesters alternate round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module hd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int HD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bios_active,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner,
  output logic              cpu_stall,
  output logic              hd_en,
  output logic              hd_we,
  output logic [ADDR_W-1:0] hd_addr,
  output logic [DATA_W-1:0] hd_wdata,
  input  logic [DATA_W-1:0] hd_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] C_LAT_LOAD = 4'(HD_LAT - 1);
  localparam logic [1:0] C_OWN_NONE = 2'b00;
  localparam logic [1:0] C_OWN_BIOS = 2'b01;
  localparam logic [1:0] C_OWN_CPU  = 2'b10;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          owner_q, owner_d;
  logic                hd_we_q, hd_we_d;
  logic [ADDR_W-1:0]   hd_addr_q, hd_addr_d;
  logic [DATA_W-1:0]   hd_wdata_q, hd_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                gnt0_w, gnt1_w;

  // On a tie the requester that was not served last wins; last_q resets to 1
  // so the BIOS takes the very first tie.
  assign gnt0_w = req0 & (bios_active | ~req1 | last_q);
  assign gnt1_w = ~bios_active & req1 & (~req0 | ~last_q);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    hd_we_d    = hd_we_q;
    hd_addr_d  = hd_addr_q;
    hd_wdata_d = hd_wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        owner_d = C_OWN_NONE;
        if (gnt0_w) begin
          state_d    = S_ACCESS;
          last_d     = 1'b0;
          cnt_d      = C_LAT_LOAD;
          owner_d    = C_OWN_BIOS;
          hd_we_d    = we0;
          hd_addr_d  = addr0;
          hd_wdata_d = wdata0;
        end else if (gnt1_w) begin
          state_d    = S_ACCESS;
          last_d     = 1'b1;
          cnt_d      = C_LAT_LOAD;
          owner_d    = C_OWN_CPU;
          hd_we_d    = we1;
          hd_addr_d  = addr1;
          hd_wdata_d = wdata1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!hd_we_q) rdata_d = hd_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = C_OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = C_OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= 4'd0;
      owner_q    <= C_OWN_NONE;
      hd_we_q    <= 1'b0;
      hd_addr_q  <= '0;
      hd_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      hd_we_q    <= hd_we_d;
      hd_addr_q  <= hd_addr_d;
      hd_wdata_q <= hd_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign hd_en     = (state_q == S_ACCESS);
  assign done0     = (state_q == S_DONE) && (owner_q == C_OWN_BIOS);
  assign done1     = (state_q == S_DONE) && (owner_q == C_OWN_CPU);
  assign owner     = owner_q;
  assign hd_we     = hd_we_q;
  assign hd_addr   = hd_addr_q;
  assign hd_wdata  = hd_wdata_q;
  assign rdata     = rdata_q;
  assign cpu_stall = req1 & ~done1;

endmodule
`default_nettype wire

// File: tb/tb_hd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd_arbiter
// Purpose  : Directed self-checking bench for hd_arbiter (HD_LAT = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              bios_active = 1'b0;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, hd_rdata = '0;
  logic              done0, done1, cpu_stall, hd_en, hd_we;
  logic [DATA_W-1:0] rdata, hd_wdata;
  logic [ADDR_W-1:0] hd_addr;
  logic [1:0]        owner;

  int n_checks = 0;
  int n_fail   = 0;

  hd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HD_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .bios_active(bios_active),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .owner(owner),
    .cpu_stall(cpu_stall), .hd_en(hd_en), .hd_we(hd_we),
    .hd_addr(hd_addr), .hd_wdata(hd_wdata), .hd_rdata(hd_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  int seq[4];
  int n_done0, n_done1, stall_err, gap_err, last_d0, n_gr;

  initial begin
    // ---------------- reset values ----------------
    #1;
    tick();
    check("rst_hd_en", 32'(hd_en), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    check("rst_hd_addr", hd_addr, 32'd0);
    check("rst_hd_wdata", hd_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_hd_we", 32'(hd_we), 32'd0);
    reset = 1'b1;

    // ---------------- BIOS read ----------------
    bios_active = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    hd_rdata = 32'h0000_0BAD;
    tick();
    check("rd_acc1_hd_en", 32'(hd_en), 32'd1);
    check("rd_acc1_owner", 32'(owner), 32'd1);
    check("rd_acc1_addr", hd_addr, 32'h10);
    check("rd_acc1_done", {30'd0, done1, done0}, 32'd0);
    hd_rdata = 32'hDEAD_BEEF;
    tick();
    check("rd_acc2_hd_en", 32'(hd_en), 32'd1);
    tick();
    check("rd_done0", 32'(done0), 32'd1);
    check("rd_done1", 32'(done1), 32'd0);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_done_hd_en", 32'(hd_en), 32'd0);
    req0 = 1'b0;
    tick();
    check("rd_idle_owner", 32'(owner), 32'd0);
    check("rd_idle_done0", 32'(done0), 32'd0);

    // ---------------- BIOS exclusivity ----------------
    req0 = 1'b1; req1 = 1'b1;
    n_done0 = 0; n_done1 = 0; stall_err = 0; gap_err = 0; last_d0 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done0) begin
        if (last_d0 >= 0 && c - last_d0 != 4) gap_err++;
        last_d0 = c;
        n_done0++;
      end
      if (done1) n_done1++;
      if (!cpu_stall) stall_err++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("excl_done0_cnt", n_done0, 5);
    check("excl_done1_cnt", n_done1, 0);
    check("excl_gap_err", gap_err, 0);
    check("excl_stall_err", stall_err, 0);
    tick();

    // ---------------- round robin ----------------
    do_reset();
    bios_active = 1'b0; req0 = 1'b1; req1 = 1'b1; hd_rdata = 32'hDEAD_BEEF;
    n_gr = 0;
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      tick();
      if (done0 || done1) begin
        seq[n_gr] = done0 ? 1 : 2;
        n_gr++;
        if (n_gr == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("rr_grant_cnt", n_gr, 4);
    if (n_gr == 4) begin
      check("rr_g0", seq[0], 1);
      check("rr_g1", seq[1], 2);
      check("rr_g2", seq[2], 1);
      check("rr_g3", seq[3], 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // ---------------- CPU write ----------------
    hd_rdata = 32'h5555_5555;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h1234;
    tick();
    check("wr_acc1_owner", 32'(owner), 32'd2);
    check("wr_acc1_hd_we", 32'(hd_we), 32'd1);
    check("wr_acc1_addr", hd_addr, 32'h40);
    check("wr_acc1_wdata", hd_wdata, 32'h1234);
    addr1 = 32'h99; wdata1 = 32'hFFFF; we1 = 1'b0;
    tick();
    check("wr_acc2_hd_en", 32'(hd_en), 32'd1);
    check("wr_acc2_addr", hd_addr, 32'h40);
    check("wr_acc2_wdata", hd_wdata, 32'h1234);
    check("wr_acc2_hd_we", 32'(hd_we), 32'd1);
    tick();
    check("wr_done1", 32'(done1), 32'd1);
    check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    req1 = 1'b0;
    tick();

    // ---------------- hand-over ----------------
    bios_active = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80;
    tick();
    check("ho_acc_owner", 32'(owner), 32'd1);
    bios_active = 1'b0;
    tick();
    check("ho_acc2_owner", 32'(owner), 32'd1);
    tick();
    check("ho_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    tick();
    check("ho_idle_owner", 32'(owner), 32'd0);
    tick();
    check("ho_cpu_owner", 32'(owner), 32'd2);
    check("ho_cpu_addr", hd_addr, 32'h80);
    tick();
    tick();
    check("ho_done1", 32'(done1), 32'd1);
    req1 = 1'b0;
    tick();

    // ---------------- mid-access reset ----------------
    bios_active = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hABCD;
    tick();
    check("mr_acc_hd_en", 32'(hd_en), 32'd1);
    reset = 1'b0;
    #1;
    check("mr_hd_en", 32'(hd_en), 32'd0);
    check("mr_owner", 32'(owner), 32'd0);
    check("mr_hd_addr", hd_addr, 32'd0);
    check("mr_hd_wdata", hd_wdata, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    req0 = 1'b0;
    n_done0 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done0 || done1) n_done0++;
    end
    check("mr_no_done", n_done0, 0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hd_arbiter.md
# hd_arbiter

Arbitrates the single hard-disk (HD) access port between the BIOS boot loader and the CPU ReadHD/WriteHD path. While the BIOS is active (`bios_active` high), only the loader is served. Once the BIOS deactivates, the two requesters share the port round-robin. The block sits between both requesters and the HD model. It latches each request, holds the HD bus for a fixed access latency, and returns read data with a one-cycle completion pulse.

## Interface
Parameters:
- `ADDR_W`, 32, HD word address width.
- `DATA_W`, 32, HD data width.
- `HD_LAT`, 2, HD access latency in cycles; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bios_active`  in  1  BIOS-active flag; high means the BIOS owns the HD exclusively.
- `req0`  in  1  BIOS loader request, level-held.
- `we0`  in  1  BIOS write enable (1 = write, 0 = read).
- `addr0`  in  ADDR_W  BIOS HD address.
- `wdata0`  in  DATA_W  BIOS write data.
- `req1`, `we1`, `addr1`, `wdata1`  in  1/1/ADDR_W/DATA_W  CPU request signals, same meaning as above.
- `done0`, `done1`  out  1  one-cycle completion pulse to the served requester.
- `rdata`  out  DATA_W  read data; valid in the `done` cycle and held until the next completion.
- `owner`  out  2  2'b00 = none, 2'b01 = BIOS, 2'b10 = CPU; valid during ACCESS and DONE.
- `cpu_stall`  out  1  combinational `req1 & ~done1`.
- `hd_en`  out  1  HD enable; high for the whole ACCESS phase.
- `hd_we`  out  1  HD write enable, latched from the granted requester.
- `hd_addr`  out  ADDR_W  HD address, latched from the granted requester.
- `hd_wdata`  out  DATA_W  HD write data, latched from the granted requester.
- `hd_rdata`  in  DATA_W  HD read data; valid in the last ACCESS cycle.

## Operation
- States:
  - IDLE, ACCESS and DONE.
  - `last` pointer: 1 bit, records the most recent grant.
  - Latency counter: 4 bits.
- IDLE:
  - Evaluates the requests every cycle.
  - If `bios_active`: grant `req0` only; `req1` waits.
  - Else, with one requester active: grant that requester.
  - Else, with both active: grant the requester that is not `last`.
  - On a grant: latch `we`, `addr` and `wdata` into the `hd_*` registers, set `owner`, set `last` to the granted index, load the counter with `HD_LAT-1`, and go to ACCESS.
  - With no grant: stay in IDLE.
- ACCESS:
  - `hd_en` is 1 for the entire phase.
  - The counter decrements each cycle.
  - At counter 0: capture `hd_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), assert the owner's `done` next cycle, and go to DONE.
- DONE:
  - `done0` or `done1` is high for exactly this cycle.
  - `hd_en` is 0.
  - Next state is IDLE unconditionally; `owner` clears to 2'b00 in IDLE.
  - Requesters drop or renew `req` after seeing `done`.
  - This gives one dead cycle, so a still-high `req` in IDLE is treated as a new request.
- Requests are not preemptible. A change of `bios_active` or of the non-owner's `req` during ACCESS or DONE has no effect until IDLE.
- Inputs of the owning requester are ignored after latching.

## Timing
- Reset (reset low, asynchronous), all outputs:
  - state = IDLE, `last` = 1 (so BIOS wins the first tie).
  - `done0` = `done1` = 0, `owner` = 0.
  - `hd_en` = `hd_we` = 0, `hd_addr` = 0, `hd_wdata` = 0, `rdata` = 0.
- Request cycle sequence, for `req` high in IDLE at cycle t:
  - ACCESS during cycles t+1 through t+HD_LAT.
  - DONE at t+HD_LAT+1.
  - IDLE at t+HD_LAT+2.
- Request-to-done latency is HD_LAT+1 cycles; minimum issue period is HD_LAT+2 cycles.
- HD_LAT=1: ACCESS lasts one cycle; the counter loads 0.
- Reset asserted mid-ACCESS: the transfer is abandoned and no `done` is issued; the requester re-requests after reset.
- If `bios_active` falls in the same cycle a CPU request appears in IDLE, the grant uses the `bios_active` value sampled that cycle.

## Test plan
- Reset and BIOS read: reset low then high, `bios_active`=1, `req0`=1, `we0`=0, `addr0`=0x10, `hd_rdata`=0xDEADBEEF, HD_LAT=2.
  - Required: `hd_en` high in 2 cycles, `done0` 3 cycles after `req0`, `rdata`=0xDEADBEEF, `owner`=01 during the access.
- BIOS exclusivity: `bios_active`=1, `req0` and `req1` both held high for 20 cycles.
  - Required: only `done0` pulses, every 4 cycles; `cpu_stall` is 1 throughout.
- Round-robin: `bios_active`=0, both requests held high.
  - Required: the grant sequence after reset is BIOS, CPU, BIOS, CPU; no requester is granted twice in a row.
- CPU write: `bios_active`=0, `req1`=1, `we1`=1, `addr1`=0x40, `wdata1`=0x1234.
  - Required: `hd_we`=1, `hd_addr`=0x40, `hd_wdata`=0x1234 for HD_LAT cycles; `rdata` unchanged; then `done1`.
- Hand-over: `bios_active` falls during a BIOS ACCESS while `req1` is pending.
  - Required: the BIOS transfer completes with `done0`, then the CPU is granted in the next IDLE.
- Mid-access reset: assert reset in the first ACCESS cycle.
  - Required: `hd_en` drops immediately, no `done` pulse, all outputs at reset values.
